dual_port_multiway_blockram: RTL and testbench

//   Set-associative successor of the single-entry dual-port block RAM: NUM_WAY ways per set, per-way and
//   per-byte write masks, write-first read forwarding, registered evict data, and a hardware clear sweep

---
 rtl/dual_port_multiway_blockram_pkg.sv | 15 +
 rtl/dual_port_multiway_blockram_way.sv | 76 +++++++
 rtl/dual_port_multiway_blockram.sv | 109 ++++++++++
 tb/tb_dual_port_multiway_blockram.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/dual_port_multiway_blockram_pkg.sv
// rtl/dual_port_multiway_blockram_pkg.sv - shared defaults and FSM encoding for the multiway block RAM
package dual_port_multiway_blockram_pkg;

    localparam int DEF_ENTRY_BITS = 64;
    localparam int DEF_NUM_WAY    = 4;
    localparam int DEF_NUM_SET    = 64;
    localparam int DEF_SET_PTR    = 6;

    // CLEAR: post-reset zeroing sweep; READY: requests honoured
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } blockram_state_e;

endpackage

// File: rtl/dual_port_multiway_blockram_way.sv
// rtl/dual_port_multiway_blockram_way.sv - one way: NUM_SET x ENTRY array, byte-masked write, registered read
//
// Ports:
//   clk_i, rst_i          clock / async active-high reset (resets only the output registers)
//   wr_en_i, wr_addr_i    write strobe for this way and target set
//   wr_byte_en_i          byte mask for the write
//   wr_data_i             write data
//   rd_en_i, rd_addr_i    read strobe / set; rd_data_o is write-first merged and held between reads
//   ev_en_i, ev_addr_i    evict capture strobe / set; ev_data_o holds the pre-write contents
module dual_port_multiway_blockram_way
    import dual_port_multiway_blockram_pkg::*;
#(
    parameter int ENTRY_BITS = DEF_ENTRY_BITS,
    parameter int NUM_SET    = DEF_NUM_SET,
    parameter int SET_PTR    = DEF_SET_PTR,
    parameter int BE_WIDTH   = ENTRY_BITS / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [SET_PTR-1:0]    wr_addr_i,
    input  logic [BE_WIDTH-1:0]   wr_byte_en_i,
    input  logic [ENTRY_BITS-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [SET_PTR-1:0]    rd_addr_i,
    output logic [ENTRY_BITS-1:0] rd_data_o,
    input  logic                  ev_en_i,
    input  logic [SET_PTR-1:0]    ev_addr_i,
    output logic [ENTRY_BITS-1:0] ev_data_o
);

    logic [ENTRY_BITS-1:0] mem_q [NUM_SET];
    logic [ENTRY_BITS-1:0] wr_merged;
    logic [ENTRY_BITS-1:0] rd_merged;
    logic [ENTRY_BITS-1:0] rd_data_q;
    logic [ENTRY_BITS-1:0] ev_data_q;

    // wr_merged: new row contents; rd_merged: same row seen by a colliding read (write-first)
    always_comb begin
        wr_merged = mem_q[wr_addr_i];
        rd_merged = mem_q[rd_addr_i];
        for (int b = 0; b < BE_WIDTH; b++) begin
            if (wr_byte_en_i[b]) begin
                wr_merged[b*8 +: 8] = wr_data_i[b*8 +: 8];
            end
            if (wr_en_i && (wr_addr_i == rd_addr_i) && wr_byte_en_i[b]) begin
                rd_merged[b*8 +: 8] = wr_data_i[b*8 +: 8];
            end
        end
    end

    // Storage has no reset; the top's clear sweep zeroes it.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_merged;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
            ev_data_q <= '0;
        end else begin
            if (rd_en_i) begin
                rd_data_q <= rd_merged;
            end
            if (ev_en_i) begin
                ev_data_q <= mem_q[ev_addr_i];
            end
        end
    end

    assign rd_data_o = rd_data_q;
    assign ev_data_o = ev_data_q;

endmodule

// File: rtl/dual_port_multiway_blockram.sv
// rtl/dual_port_multiway_blockram.sv - set-associative dual-port RAM with evict data and post-reset clear
//
// Ports:
//   clk_in, reset_in               clock / async active-high reset
//   init_done_out                  high once the clear sweep has zeroed every set
//   read_en_in, read_set_addr_in   read request; read_valid_out/read_entry_out one cycle later
//   write_en_in, write_set_addr_in write request; way mask, byte mask and data replicated to selected ways
//   evict_valid_out/evict_entry_out pre-write contents of the written set, one cycle after the write
module dual_port_multiway_blockram
    import dual_port_multiway_blockram_pkg::*;
#(
    parameter int SINGLE_ENTRY_SIZE_IN_BITS = DEF_ENTRY_BITS,
    parameter int NUM_WAY                   = DEF_NUM_WAY,
    parameter int NUM_SET                   = DEF_NUM_SET,
    parameter int SET_PTR_WIDTH_IN_BITS     = DEF_SET_PTR
) (
    input  logic                                         clk_in,
    input  logic                                         reset_in,
    output logic                                         init_done_out,
    input  logic                                         read_en_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]             read_set_addr_in,
    output logic                                         read_valid_out,
    output logic [NUM_WAY*SINGLE_ENTRY_SIZE_IN_BITS-1:0] read_entry_out,
    input  logic                                         write_en_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]             write_set_addr_in,
    input  logic [NUM_WAY-1:0]                           write_way_en_in,
    input  logic [SINGLE_ENTRY_SIZE_IN_BITS/8-1:0]       write_byte_en_in,
    input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]         write_entry_in,
    output logic                                         evict_valid_out,
    output logic [NUM_WAY*SINGLE_ENTRY_SIZE_IN_BITS-1:0] evict_entry_out
);

    localparam int ENTRY         = SINGLE_ENTRY_SIZE_IN_BITS;
    localparam int BYTE_EN_WIDTH = ENTRY / 8;
    localparam logic [SET_PTR_WIDTH_IN_BITS-1:0] LAST_SET = SET_PTR_WIDTH_IN_BITS'(NUM_SET - 1);

    blockram_state_e                  state_q, state_d;
    logic [SET_PTR_WIDTH_IN_BITS-1:0] cnt_q, cnt_d;
    logic                             read_valid_q, evict_valid_q;
    logic                             ready;
    logic [SET_PTR_WIDTH_IN_BITS-1:0] wr_addr;
    logic [BYTE_EN_WIDTH-1:0]         wr_be;
    logic [ENTRY-1:0]                 wr_data;

    assign ready = (state_q == ST_READY);

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q       <= ST_CLEAR;
            cnt_q         <= '0;
            read_valid_q  <= 1'b0;
            evict_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            read_valid_q  <= ready && read_en_in;
            evict_valid_q <= ready && write_en_in;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_SET) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end
            end
            default: ;
        endcase
    end

    // During the sweep the write port is taken over to zero set cnt_q in every way.
    always_comb begin
        wr_addr = ready ? write_set_addr_in : cnt_q;
        wr_be   = ready ? write_byte_en_in : '1;
        wr_data = ready ? write_entry_in : '0;
    end

    for (genvar w = 0; w < NUM_WAY; w++) begin : g_way
        dual_port_multiway_blockram_way #(
            .ENTRY_BITS (ENTRY),
            .NUM_SET    (NUM_SET),
            .SET_PTR    (SET_PTR_WIDTH_IN_BITS),
            .BE_WIDTH   (BYTE_EN_WIDTH)
        ) u_way (
            .clk_i        (clk_in),
            .rst_i        (reset_in),
            .wr_en_i      (ready ? (write_en_in && write_way_en_in[w]) : 1'b1),
            .wr_addr_i    (wr_addr),
            .wr_byte_en_i (wr_be),
            .wr_data_i    (wr_data),
            .rd_en_i      (ready && read_en_in),
            .rd_addr_i    (read_set_addr_in),
            .rd_data_o    (read_entry_out[w*ENTRY +: ENTRY]),
            .ev_en_i      (ready && write_en_in),
            .ev_addr_i    (write_set_addr_in),
            .ev_data_o    (evict_entry_out[w*ENTRY +: ENTRY])
        );
    end

    assign init_done_out   = ready;
    assign read_valid_out  = read_valid_q;
    assign evict_valid_out = evict_valid_q;

endmodule

// File: tb/tb_dual_port_multiway_blockram.sv
// tb/tb_dual_port_multiway_blockram.sv - self-checking bench for dual_port_multiway_blockram
module tb_dual_port_multiway_blockram;

    localparam logic [63:0] Z = 64'h0;
    localparam logic [63:0] A = 64'hFFFFFFFF_00000000;
    localparam logic [63:0] B = 64'h00000000_FFFFFFFF;
    localparam logic [63:0] O = 64'hFFFFFFFF_FFFFFFFF;

    logic         clk_in = 1'b0;
    logic         reset_in;
    logic         init_done_out;
    logic         read_en_in;
    logic [5:0]   read_set_addr_in;
    logic         read_valid_out;
    logic [255:0] read_entry_out;
    logic         write_en_in;
    logic [5:0]   write_set_addr_in;
    logic [3:0]   write_way_en_in;
    logic [7:0]   write_byte_en_in;
    logic [63:0]  write_entry_in;
    logic         evict_valid_out;
    logic [255:0] evict_entry_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_in = ~clk_in;

    dual_port_multiway_blockram dut (
        .clk_in            (clk_in),
        .reset_in          (reset_in),
        .init_done_out     (init_done_out),
        .read_en_in        (read_en_in),
        .read_set_addr_in  (read_set_addr_in),
        .read_valid_out    (read_valid_out),
        .read_entry_out    (read_entry_out),
        .write_en_in       (write_en_in),
        .write_set_addr_in (write_set_addr_in),
        .write_way_en_in   (write_way_en_in),
        .write_byte_en_in  (write_byte_en_in),
        .write_entry_in    (write_entry_in),
        .evict_valid_out   (evict_valid_out),
        .evict_entry_out   (evict_entry_out)
    );

    typedef struct {
        logic         rd_en;
        logic [5:0]   rd_set;
        logic         wr_en;
        logic [5:0]   wr_set;
        logic [3:0]   way;
        logic [7:0]   be;
        logic [63:0]  data;
        logic         exp_rv;
        logic [255:0] exp_re;
        logic         exp_ev;
        logic [255:0] exp_ee;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    function automatic vec_t mk(logic rd_en, logic [5:0] rs, logic wr_en, logic [5:0] ws,
                                logic [3:0] way, logic [7:0] be, logic [63:0] d,
                                logic erv, logic [255:0] ere, logic eev, logic [255:0] eee);
        vec_t v;
        v.rd_en = rd_en; v.rd_set = rs; v.wr_en = wr_en; v.wr_set = ws;
        v.way = way; v.be = be; v.data = d;
        v.exp_rv = erv; v.exp_re = ere; v.exp_ev = eev; v.exp_ee = eee;
        return v;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        read_en_in        = 1'b0;
        read_set_addr_in  = '0;
        write_en_in       = 1'b0;
        write_set_addr_in = '0;
        write_way_en_in   = '0;
        write_byte_en_in  = '0;
        write_entry_in    = '0;
    endtask

    // Release reset away from the edge, count cycles until init_done rises, count stray valid pulses.
    task automatic sweep(input string name, input int stop_after, output int cycles, output int strays);
        cycles = 0;
        strays = 0;
        @(negedge clk_in);
        reset_in = 1'b0;
        while (!init_done_out && cycles < 200 && (stop_after < 0 || cycles < stop_after)) begin
            @(posedge clk_in);
            #1;
            cycles++;
            if (read_valid_out || evict_valid_out) strays++;
        end
        if (stop_after < 0 && !init_done_out) begin
            check({name, "_timeout"}, {255'd0, init_done_out}, 256'd1);
        end
    endtask

    initial begin
        int cyc, strays;
        reset_in = 1'b1;
        idle_inputs();

        vecs[0]  = mk(1, 63, 0, 0,  4'b0000, 8'h00, Z, 1, 256'd0,          0, 256'd0);
        vecs[1]  = mk(0, 0,  1, 5,  4'b0010, 8'hFF, A, 0, 256'd0,          1, 256'd0);
        vecs[2]  = mk(1, 5,  0, 0,  4'b0000, 8'h00, Z, 1, {Z, Z, A, Z},    0, 256'd0);
        vecs[3]  = mk(0, 0,  0, 0,  4'b0000, 8'h00, Z, 0, {Z, Z, A, Z},    0, 256'd0);
        vecs[4]  = mk(1, 62, 1, 62, 4'b0001, 8'hFF, O, 1, {Z, Z, Z, O},    1, 256'd0);
        vecs[5]  = mk(0, 0,  1, 61, 4'b1000, 8'hFF, B, 0, {Z, Z, Z, O},    1, 256'd0);
        vecs[6]  = mk(0, 0,  1, 61, 4'b1000, 8'hFF, A, 0, {Z, Z, Z, O},    1, {B, Z, Z, Z});
        vecs[7]  = mk(1, 61, 0, 0,  4'b0000, 8'h00, Z, 1, {A, Z, Z, Z},    0, {B, Z, Z, Z});
        vecs[8]  = mk(0, 0,  1, 60, 4'b0001, 8'hFF, O, 0, {A, Z, Z, Z},    1, 256'd0);
        vecs[9]  = mk(0, 0,  1, 60, 4'b0001, 8'h0F, Z, 0, {A, Z, Z, Z},    1, {Z, Z, Z, O});
        vecs[10] = mk(1, 60, 0, 0,  4'b0000, 8'h00, Z, 1, {Z, Z, Z, A},    0, {Z, Z, Z, O});
        vecs[11] = mk(1, 60, 0, 60, 4'b0001, 8'hFF, 64'h1234, 1, {Z, Z, Z, A}, 0, {Z, Z, Z, O});
        vecs[12] = mk(0, 0,  1, 5,  4'b0000, 8'hFF, O, 0, {Z, Z, Z, A},    1, {Z, Z, A, Z});
        vecs[13] = mk(1, 5,  1, 5,  4'b1111, 8'h00, O, 1, {Z, Z, A, Z},    1, {Z, Z, A, Z});
        vecs[14] = mk(1, 8,  1, 7,  4'b0101, 8'hF0, O, 1, 256'd0,          1, 256'd0);
        vecs[15] = mk(1, 7,  0, 0,  4'b0000, 8'h00, Z, 1, {Z, A, Z, A},    0, 256'd0);

        repeat (3) @(posedge clk_in);
        #1;
        check("rst_init_done", {255'd0, init_done_out}, 256'd0);
        check("rst_read_valid", {255'd0, read_valid_out}, 256'd0);
        check("rst_evict_valid", {255'd0, evict_valid_out}, 256'd0);
        check("rst_read_entry", read_entry_out, 256'd0);
        check("rst_evict_entry", evict_entry_out, 256'd0);

        // Requests held active through the sweep must be dropped.
        read_en_in = 1'b1; read_set_addr_in = 6'd63;
        write_en_in = 1'b1; write_set_addr_in = 6'd63;
        write_way_en_in = 4'hF; write_byte_en_in = 8'hFF; write_entry_in = O;
        sweep("sweep1", -1, cyc, strays);
        check("sweep1_cycles", 256'(cyc), 256'd64);
        check("sweep1_strays", 256'(strays), 256'd0);
        idle_inputs();

        for (int i = 0; i < NV; i++) begin
            read_en_in        = vecs[i].rd_en;
            read_set_addr_in  = vecs[i].rd_set;
            write_en_in       = vecs[i].wr_en;
            write_set_addr_in = vecs[i].wr_set;
            write_way_en_in   = vecs[i].way;
            write_byte_en_in  = vecs[i].be;
            write_entry_in    = vecs[i].data;
            @(posedge clk_in);
            #1;
            check($sformatf("v%0d_read_valid", i), {255'd0, read_valid_out}, {255'd0, vecs[i].exp_rv});
            check($sformatf("v%0d_read_entry", i), read_entry_out, vecs[i].exp_re);
            check($sformatf("v%0d_evict_valid", i), {255'd0, evict_valid_out}, {255'd0, vecs[i].exp_ev});
            check($sformatf("v%0d_evict_entry", i), evict_entry_out, vecs[i].exp_ee);
        end
        idle_inputs();
        @(posedge clk_in);
        #1;
        check("pulse_read_valid_drop", {255'd0, read_valid_out}, 256'd0);
        check("pulse_evict_valid_drop", {255'd0, evict_valid_out}, 256'd0);

        // Reset after writes, then again at sweep set 20.
        reset_in = 1'b1;
        #1;
        check("midop_init_done", {255'd0, init_done_out}, 256'd0);
        check("midop_read_entry", read_entry_out, 256'd0);
        @(posedge clk_in);
        #1;
        read_en_in = 1'b1; read_set_addr_in = 6'd5;
        write_en_in = 1'b1; write_set_addr_in = 6'd5;
        write_way_en_in = 4'hF; write_byte_en_in = 8'hFF; write_entry_in = O;
        sweep("partial", 20, cyc, strays);
        check("partial_cycles", 256'(cyc), 256'd20);
        check("partial_init_done", {255'd0, init_done_out}, 256'd0);
        reset_in = 1'b1;
        #1;
        check("midsweep_init_done", {255'd0, init_done_out}, 256'd0);
        @(posedge clk_in);
        #1;
        sweep("sweep2", -1, cyc, strays);
        check("sweep2_cycles", 256'(cyc), 256'd64);
        check("sweep2_strays", 256'(strays), 256'd0);
        idle_inputs();

        for (int s = 0; s < 64; s++) begin
            read_en_in = 1'b1;
            read_set_addr_in = 6'(s);
            @(posedge clk_in);
            #1;
            check($sformatf("clear_set%0d", s), {read_valid_out, read_entry_out[254:0]},
                  {1'b1, 255'd0});
            check($sformatf("clear_set%0d_top", s), {255'd0, read_entry_out[255]}, 256'd0);
        end
        idle_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
